// File: rtl/cpu_bus_pkg.sv
// Constants shared by the CPU control unit and its bus targets: IO register map,
// read-handshake FSM states and the stack layout inside RAM.
package cpu_bus_pkg;

  localparam logic [15:0] IO_BASE    = 16'h8000;
  localparam logic [7:0]  IO_OUT     = 8'h00;
  localparam logic [7:0]  IO_IN      = 8'h01;
  localparam logic [7:0]  IO_STAT    = 8'h02;
  localparam logic [7:0]  IO_TLO     = 8'h04;
  localparam logic [7:0]  IO_THI     = 8'h05;

  localparam logic [15:0] STACK_BASE = 16'h7F00;
  localparam logic [15:0] STACK_TOP  = 16'h7FFF;

  typedef enum logic {IDLE, ARMED} rd_state_e;

endpackage

// File: rtl/sync_ram_8.sv
// Single-port byte RAM with synchronous write and registered read; the read
// register only loads when re_i is high so it holds data for a later OE phase.
module sync_ram_8 #(
  parameter int unsigned RAM_AW = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**RAM_AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= 8'h00;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_io_responder.sv
// Bus target for the CPU memory strobes: RAM below the IO window plus OUT/IN/STATUS
// registers. Define MEM_IO_TIMER_EN to add the 16-bit timer at IO offsets 4/5.
module mem_io_responder #(
  parameter int unsigned RAM_AW  = 15,
  parameter logic [15:0] IO_BASE = 16'h8000,
  parameter int unsigned SYNC_FF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce,
  input  logic        mem_r,
  input  logic        mem_oe,
  input  logic        mem_w,
  input  logic        mem_rst,
  input  logic [15:0] addr_bus_in,
  input  logic [7:0]  data_bus_in,
  output logic [7:0]  data_bus_out,
  output logic        data_oe,
  output logic [7:0]  io_out_port,
  input  logic [7:0]  io_in_port,
  output logic        bus_err
);

  import cpu_bus_pkg::*;

  rd_state_e state_q, state_d;
  logic [15:0] addr_q;
  logic [7:0]  io_rdata_q, out_q, io_val, ram_rdata, drv_data;
  logic [SYNC_FF-1:0][7:0] sync_q;
  logic err_q, err_set, oe_drive;
  logic act, wr_en, rd_en, io_hit, ram_hit, ram_sel;
  logic [7:0] io_off;

  // mem_rst takes priority over every other strobe in the same cycle
  assign act     = mem_ce & ~mem_rst;
  assign wr_en   = act & mem_w;
  assign rd_en   = act & mem_r & ~mem_w;
  assign io_hit  = (addr_bus_in[15:8] == IO_BASE[15:8]);
  assign ram_hit = ((addr_bus_in >> RAM_AW) == 16'd0);
  assign io_off  = addr_bus_in[7:0];
  assign ram_sel = ((addr_q >> RAM_AW) == 16'd0);

  sync_ram_8 #(.RAM_AW(RAM_AW)) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en & ram_hit),
    .re_i    (rd_en & ram_hit),
    .addr_i  (addr_bus_in[RAM_AW-1:0]),
    .wdata_i (data_bus_in),
    .rdata_o (ram_rdata)
  );

`ifdef MEM_IO_TIMER_EN
  logic [15:0] tmr_q;
  logic [7:0]  tmr_hi_q;

  always_ff @(posedge clk) begin
    if (rst || (wr_en && io_hit && io_off == IO_TLO)) begin
      tmr_q    <= 16'h0000;
      tmr_hi_q <= 8'h00;
    end else begin
      tmr_q <= tmr_q + 16'd1;
      if (rd_en && io_hit && io_off == IO_TLO) tmr_hi_q <= tmr_q[15:8];
    end
  end
`endif

  always_comb begin
    io_val = 8'h00;
    if (io_hit) begin
      case (io_off)
        IO_OUT:  io_val = out_q;
        IO_IN:   io_val = sync_q[SYNC_FF-1];
        IO_STAT: io_val = {7'b0, err_q};
`ifdef MEM_IO_TIMER_EN
        IO_TLO:  io_val = tmr_q[7:0];
        IO_THI:  io_val = tmr_hi_q;
`endif
        default: io_val = 8'h00;
      endcase
    end
  end

  // OE drives whatever was latched while ARMED; OE while IDLE answers FF and flags an error
  always_comb begin
    state_d  = state_q;
    oe_drive = 1'b0;
    drv_data = 8'hFF;
    err_set  = 1'b0;
    if (!mem_ce || mem_rst) begin
      state_d = IDLE;
    end else begin
      if (mem_oe) begin
        oe_drive = 1'b1;
        if (state_q == ARMED) drv_data = ram_sel ? ram_rdata : io_rdata_q;
        else                  err_set  = 1'b1;
      end
      if (mem_w) begin
        state_d = IDLE;
        if (mem_r) err_set = 1'b1;
      end else if (mem_r) begin
        state_d = ARMED;
      end else if (mem_oe && state_q == ARMED) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      io_rdata_q <= 8'h00;
      out_q      <= 8'h00;
      err_q      <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q[0] <= io_in_port;
      for (int i = 1; i < SYNC_FF; i++) sync_q[i] <= sync_q[i-1];
      if (rd_en) begin
        addr_q     <= addr_bus_in;
        io_rdata_q <= io_val;
      end
      if (mem_ce && mem_rst) begin
        out_q <= 8'h00;
        err_q <= 1'b0;
      end else begin
        if (wr_en && io_hit && io_off == IO_OUT) out_q <= data_bus_in;
        if (err_set) err_q <= 1'b1;
        else if (wr_en && io_hit && io_off == IO_STAT && data_bus_in[0]) err_q <= 1'b0;
      end
    end
  end

  assign data_oe      = oe_drive;
  assign data_bus_out = oe_drive ? drv_data : 8'hzz;
  assign io_out_port  = out_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed scenarios then random bus traffic
// checked against an address-map reference model.
`timescale 1ns/1ps
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst, mem_ce, mem_r, mem_oe, mem_w, mem_rst;
  logic [15:0] addr_bus_in;
  logic [7:0]  data_bus_in, data_bus_out, io_out_port, io_in_port;
  logic        data_oe, bus_err;

  int checks = 0;
  int passes = 0;

  logic [7:0] expQ[$];
  logic [7:0] refRam [int];
  logic [7:0] refOut, refRdata, refIn;
  logic       refErr, refArmed;
`ifdef MEM_IO_TIMER_EN
  logic [15:0] refTmr;
  logic [7:0]  refTmrHi;
`endif

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ce       (mem_ce),
    .mem_r        (mem_r),
    .mem_oe       (mem_oe),
    .mem_w        (mem_w),
    .mem_rst      (mem_rst),
    .addr_bus_in  (addr_bus_in),
    .data_bus_in  (data_bus_in),
    .data_bus_out (data_bus_out),
    .data_oe      (data_oe),
    .io_out_port  (io_out_port),
    .io_in_port   (io_in_port),
    .bus_err      (bus_err)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // What a read of address a returns, from the memory map alone
  function automatic logic [7:0] refRead(input logic [15:0] a);
    if (a < 16'h8000) return refRam.exists(int'(a)) ? refRam[int'(a)] : 8'h00;
    if (a == 16'h8000) return refOut;
    if (a == 16'h8001) return refIn;
    if (a == 16'h8002) return {7'b0, refErr};
`ifdef MEM_IO_TIMER_EN
    if (a == 16'h8004) return refTmr[7:0];
    if (a == 16'h8005) return refTmrHi;
`endif
    return 8'h00;
  endfunction

  // Called at a negedge: drives one bus cycle, advances the model, then checks
  // the registered outputs at the following negedge.
  task automatic applyStimulus(input logic ce, input logic r, input logic oe, input logic w,
                               input logic mr, input logic [15:0] a, input logic [7:0] d);
    logic errSet, errClr;
    mem_ce = ce; mem_r = r; mem_oe = oe; mem_w = w; mem_rst = mr;
    addr_bus_in = a; data_bus_in = d;
    errSet = 1'b0;
    errClr = 1'b0;
    if (!ce) begin
      refArmed = 1'b0;
    end else if (mr) begin
      refOut = 8'h00; refErr = 1'b0; refArmed = 1'b0;
    end else begin
      if (oe) begin
        expQ.push_back(refArmed ? refRdata : 8'hFF);
        if (!refArmed) errSet = 1'b1;
      end
      if (w) begin
        if (r) errSet = 1'b1;
        if (a < 16'h8000) refRam[int'(a)] = d;
        else if (a == 16'h8000) refOut = d;
        else if (a == 16'h8002 && d[0]) errClr = 1'b1;
        refArmed = 1'b0;
      end else if (r) begin
        refRdata = refRead(a);
`ifdef MEM_IO_TIMER_EN
        if (a == 16'h8004) refTmrHi = refTmr[15:8];
`endif
        refArmed = 1'b1;
      end else if (oe) begin
        refArmed = 1'b0;
      end
      if (errSet) refErr = 1'b1;
      else if (errClr) refErr = 1'b0;
    end
`ifdef MEM_IO_TIMER_EN
    if (ce && !mr && w && a == 16'h8004) begin refTmr = 16'h0000; refTmrHi = 8'h00; end
    else refTmr = refTmr + 16'd1;
`endif
    @(negedge clk);
    checkOutput("io_out_port", {8'h00, io_out_port}, {8'h00, refOut});
    checkOutput("bus_err", {15'h0, bus_err}, {15'h0, refErr});
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wrCycle(input logic [15:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rdPair(input logic [15:0] a);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // Monitor: every cycle the DUT drives the bus must match the oldest expected read
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (data_oe === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_oe: data_oe=1 data=%h, expected no drive", data_bus_out);
        end else begin
          e = expQ.pop_front();
          checkOutput("read_data", {8'h00, data_bus_out}, {8'h00, e});
        end
      end
    end
  end

  initial begin
    logic [15:0] pool [20];
    logic [15:0] a;
    pool = '{16'h0000, 16'h0010, 16'h0020, 16'h1234, 16'h4000, 16'h7EFF, 16'h7F00, 16'h7F80,
             16'h7FFF, 16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8004, 16'h8005, 16'h80FF,
             16'h8100, 16'h9000, 16'hFFFF, 16'h2222};

    rst = 1'b1; mem_ce = 1'b0; mem_r = 1'b0; mem_oe = 1'b0; mem_w = 1'b0; mem_rst = 1'b0;
    addr_bus_in = 16'h0000; data_bus_in = 8'h00; io_in_port = 8'h00;
    refOut = 8'h00; refRdata = 8'h00; refIn = 8'h00; refErr = 1'b0; refArmed = 1'b0;
`ifdef MEM_IO_TIMER_EN
    refTmr = 16'h0000; refTmrHi = 8'h00;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_io_out", {8'h00, io_out_port}, 16'h0000);
    checkOutput("reset_bus_err", {15'h0, bus_err}, 16'h0000);
    checkOutput("reset_data_oe", {15'h0, data_oe}, 16'h0000);

    $display("[TB] stack RAM write and read");
    wrCycle(16'h7F00, 8'h5A);
    rdPair(16'h7F00);

    $display("[TB] OUT and synchronised IN registers");
    wrCycle(16'h8000, 8'h3C);
    io_in_port = 8'hA5; refIn = 8'hA5;
    repeat (3) idleCycle();
    rdPair(16'h8001);

    $display("[TB] OE without R, STATUS read and clear");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    rdPair(16'h8002);
    wrCycle(16'h8002, 8'h01);

    $display("[TB] re-armed read and dropped chip enable");
    wrCycle(16'h0010, 8'h11);
    wrCycle(16'h0020, 8'h22);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 8'h00);
    rdPair(16'h0020);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 8'h00);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    wrCycle(16'h8002, 8'h01);

    $display("[TB] soft reset while armed");
    wrCycle(16'h8000, 8'h3C);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7F00, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h7F00, 8'hEE);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    rdPair(16'h7F00);
    rdPair(16'h0020);
    wrCycle(16'h8002, 8'h01);

    $display("[TB] timer window");
    wrCycle(16'h8004, 8'h00);
    repeat (300) idleCycle();
    rdPair(16'h8004);
    rdPair(16'h8005);

    $display("[TB] random traffic");
    foreach (pool[i]) if (pool[i] < 16'h8000) wrCycle(pool[i], 8'($urandom));
    io_in_port = 8'($urandom); refIn = io_in_port;
    repeat (3) idleCycle();
    for (int n = 0; n < 1500; n++) begin
      a = pool[$urandom_range(0, 19)];
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 39) == 0, a, 8'($urandom));
    end

    repeat (2) idleCycle();
    checkOutput("pending_reads", 16'(expQ.size()), 16'h0000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
